alu_trojan_seq: RTL and testbench

Parametrised, registered successor to the 4-bit combinational trojan ALU.
- WIDTH-bit ALU (ADD/SUB/AND/OR) with valid/ready handshakes on input and output, and a one-cycle result register.
- Stateful sequence trigger: the trojan arms only after TRIG_COUNT consecutive matching operations.
- Once armed, it corrupts a bounded window of PAYLOAD_LEN results, then disarms itself.
- Used as the trojan-research core behind the TinyTapeout wrapper, and as a detection-bench target.

---
 rtl/alu_trojan_pkg.sv | 17 +
 rtl/trojan_trigger_fsm.sv | 87 ++++++++
 rtl/alu_trojan_seq.sv | 90 +++++++++
 tb/tb_alu_trojan_seq.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_trojan_pkg.sv
// Shared opcode and trigger-FSM state encodings for the sequential trojan ALU.
package alu_trojan_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_COUNT = 2'b01,
    ST_ARMED = 2'b10
  } trig_state_e;

endpackage : alu_trojan_pkg

// File: rtl/trojan_trigger_fsm.sv
// Sequence trigger: arms after TRIG_COUNT consecutive matching accepted ops,
// then flags the next PAYLOAD_LEN accepted ops for corruption and disarms.
module trojan_trigger_fsm
  import alu_trojan_pkg::*;
#(
  parameter int unsigned TRIG_COUNT  = 3,
  parameter int unsigned PAYLOAD_LEN = 2,
  parameter bit          TROJAN_EN   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic accept,
  input  logic match,
  output logic corrupt,
  output logic armed
);

  localparam int unsigned CW = $clog2(TRIG_COUNT + 1);
  localparam int unsigned PW = $clog2(PAYLOAD_LEN + 1);

  trig_state_e   state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [PW-1:0] pay, pay_nxt;

  // State, match counter and payload counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      count <= '0;
      pay   <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      pay   <= pay_nxt;
    end
  end

  // Next-state logic; only accepted ops move the FSM.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    pay_nxt   = pay;
    if (TROJAN_EN && accept) begin
      case (state)
        ST_IDLE: begin
          if (match) begin
            count_nxt = CW'(1);
            if (TRIG_COUNT == 1) begin
              state_nxt = ST_ARMED;
              pay_nxt   = PW'(PAYLOAD_LEN);
            end else begin
              state_nxt = ST_COUNT;
            end
          end
        end
        ST_COUNT: begin
          if (match) begin
            count_nxt = count + CW'(1);
            if (count == CW'(TRIG_COUNT - 1)) begin
              state_nxt = ST_ARMED;
              pay_nxt   = PW'(PAYLOAD_LEN);
            end
          end else begin
            count_nxt = '0;
            state_nxt = ST_IDLE;
          end
        end
        ST_ARMED: begin
          pay_nxt = pay - PW'(1);
          if (pay == PW'(1)) begin
            state_nxt = ST_IDLE;
            count_nxt = '0;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          count_nxt = '0;
        end
      endcase
    end
  end

  // The op completing the trigger is clean; payload starts with the next one.
  assign armed   = (state == ST_ARMED);
  assign corrupt = accept && armed;

endmodule : trojan_trigger_fsm

// File: rtl/alu_trojan_seq.sv
// Registered WIDTH-bit ALU with valid/ready handshakes and a sequence-triggered
// trojan that flips res LSB and cout on a bounded window of results.
module alu_trojan_seq
  import alu_trojan_pkg::*;
#(
  parameter int unsigned       WIDTH       = 8,
  parameter bit                TROJAN_EN   = 1'b1,
  parameter logic [WIDTH-1:0]  KEY_A       = WIDTH'(8'hA5),
  parameter logic [WIDTH-1:0]  KEY_B       = WIDTH'(8'h3C),
  parameter logic [1:0]        KEY_OP      = 2'b00,
  parameter int unsigned       TRIG_COUNT  = 3,
  parameter int unsigned       PAYLOAD_LEN = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             zero,
  output logic             dbg_armed
);

  logic             accept;
  logic             match;
  logic             corrupt;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout;
  logic [WIDTH-1:0] res_nxt;
  logic             cout_nxt;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign match    = (a == KEY_A) && (b == KEY_B) && (op == KEY_OP);

  trojan_trigger_fsm #(
    .TRIG_COUNT (TRIG_COUNT),
    .PAYLOAD_LEN(PAYLOAD_LEN),
    .TROJAN_EN  (TROJAN_EN)
  ) u_trig (
    .clk    (clk),
    .rst_n  (rst_n),
    .accept (accept),
    .match  (match),
    .corrupt(corrupt),
    .armed  (dbg_armed)
  );

  // ALU datapath; the extra MSB of diff is the unsigned borrow (a < b).
  always_comb begin
    sum      = {1'b0, a} + {1'b0, b};
    diff     = {1'b0, a} - {1'b0, b};
    alu_res  = '0;
    alu_cout = 1'b0;
    case (op)
      ALU_ADD: begin alu_res = sum[WIDTH-1:0];  alu_cout = sum[WIDTH];  end
      ALU_SUB: begin alu_res = diff[WIDTH-1:0]; alu_cout = diff[WIDTH]; end
      ALU_AND: alu_res = a & b;
      ALU_OR:  alu_res = a | b;
      default: alu_res = '0;
    endcase
    res_nxt  = alu_res ^ WIDTH'(corrupt);
    cout_nxt = alu_cout ^ corrupt;
  end

  // Output register: load on accept, clear valid on drain, hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      res       <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      res       <= res_nxt;
      cout      <= cout_nxt;
      zero      <= (res_nxt == '0);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule : alu_trojan_seq

// File: tb/tb_alu_trojan_seq.sv
// Scoreboard bench for alu_trojan_seq: default instance plus a 4-bit
// instance with the trojan disabled.
module tb_alu_trojan_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] a, b, res;
  logic [1:0] op;
  logic       cout, zero, dbg_armed;

  logic       d4_in_valid, d4_in_ready, d4_out_valid, d4_out_ready;
  logic [3:0] d4_a, d4_b, d4_res;
  logic [1:0] d4_op;
  logic       d4_cout, d4_zero, d4_dbg_armed;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_trojan_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .cout(cout), .zero(zero), .dbg_armed(dbg_armed)
  );

  alu_trojan_seq #(
    .WIDTH(4), .TROJAN_EN(1'b0), .KEY_A(4'h9), .KEY_B(4'h6)
  ) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(d4_in_valid), .in_ready(d4_in_ready),
    .a(d4_a), .b(d4_b), .op(d4_op), .out_valid(d4_out_valid),
    .out_ready(d4_out_ready), .res(d4_res), .cout(d4_cout), .zero(d4_zero),
    .dbg_armed(d4_dbg_armed)
  );

  // Independent reference for clean (uncorrupted) results: {cout, res}.
  function automatic logic [8:0] ref_alu(input logic [7:0] x, input logic [7:0] y,
                                         input logic [1:0] o);
    case (o)
      2'b00:   return {1'b0, x} + {1'b0, y};
      2'b01:   return {(x < y), 8'(x - y)};
      2'b10:   return {1'b0, x & y};
      default: return {1'b0, x | y};
    endcase
  endfunction

  // Pops one expected result per drained output.
  task automatic monitor();
    logic [9:0] got, exp;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        got = {res, cout, zero};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_extra: got res=%h cout=%b zero=%b with nothing expected",
                   res, cout, zero);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL scoreboard: got res=%h cout=%b zero=%b, expected res=%h cout=%b zero=%b",
                     res, cout, zero, exp[9:2], exp[1], exp[0]);
          end
        end
      end
    end
  endtask

  // Called at posedge+1; presents one op and returns at posedge+1 after acceptance.
  task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [1:0] top,
                      input logic [7:0] eres, input logic ecout);
    bit acc = 1'b0;
    int n   = 0;
    a = ta; b = tb; op = top; in_valid = 1'b1;
    exp_q.push_back({eres, ecout, (eres == 8'h00)});
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: op %h,%h,%b never accepted (in_ready=%b)", ta, tb, top, in_ready);
    end
  endtask

  task automatic chk_armed(input string name, input logic exp);
    checks++;
    if (dbg_armed !== exp) begin
      errors++;
      $display("FAIL %s: dbg_armed=%b expected %b", name, dbg_armed, exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = '0;
    d4_in_valid = 1'b0; d4_out_ready = 1'b1; d4_a = '0; d4_b = '0; d4_op = '0;
    #3;
    checks++;
    if ({out_valid, res, cout, zero, dbg_armed, in_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: valid=%b res=%h cout=%b zero=%b armed=%b in_ready=%b, expected 0,00,0,0,0,1",
               out_valid, res, cout, zero, dbg_armed, in_ready);
    end
    checks++;
    if ({d4_out_valid, d4_res, d4_cout, d4_zero, d4_dbg_armed} !== 8'h00) begin
      errors++;
      $display("FAIL reset_state_w4: valid=%b res=%h cout=%b zero=%b armed=%b, expected all 0",
               d4_out_valid, d4_res, d4_cout, d4_zero, d4_dbg_armed);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_normal_ops();
    send(8'h05, 8'h03, 2'b00, 8'h08, 1'b0);
    send(8'h03, 8'h05, 2'b01, 8'hFE, 1'b1);
    send(8'hFF, 8'h01, 2'b00, 8'h00, 1'b1);
    send(8'hCC, 8'hAA, 2'b10, 8'h88, 1'b0);
    send(8'h0F, 8'hF0, 2'b11, 8'hFF, 1'b0);
    chk_armed("normal_not_armed", 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] ra, rb;
    logic [1:0] ro;
    logic [8:0] r;
    int c0;
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      ro = 2'($urandom_range(0, 3));
      if (ra == 8'hA5) ra = 8'h5A;
      r = ref_alu(ra, rb, ro);
      send(ra, rb, ro, r[7:0], r[8]);
    end
    checks++;
    if (cyc - c0 != 8) begin
      errors++;
      $display("FAIL back_to_back_throughput: 8 ops took %0d cycles, expected 8", cyc - c0);
    end
  endtask

  task automatic test_arm_payload();
    send(8'hA5, 8'h3C, 2'b00, 8'hE1, 1'b0);
    chk_armed("arm_after_1", 1'b0);
    send(8'hA5, 8'h3C, 2'b00, 8'hE1, 1'b0);
    chk_armed("arm_after_2", 1'b0);
    send(8'hA5, 8'h3C, 2'b00, 8'hE1, 1'b0);
    chk_armed("arm_after_3", 1'b1);
    send(8'h10, 8'h20, 2'b00, 8'h31, 1'b1);
    chk_armed("payload_1", 1'b1);
    send(8'h07, 8'h03, 2'b10, 8'h02, 1'b1);
    chk_armed("payload_done", 1'b0);
    send(8'h10, 8'h20, 2'b00, 8'h30, 1'b0);
  endtask

  task automatic test_broken_sequence();
    send(8'hA5, 8'h3C, 2'b00, 8'hE1, 1'b0);
    send(8'hA5, 8'h3C, 2'b00, 8'hE1, 1'b0);
    chk_armed("broken_2", 1'b0);
    send(8'h01, 8'h01, 2'b00, 8'h02, 1'b0);
    send(8'hA5, 8'h3C, 2'b00, 8'hE1, 1'b0);
    send(8'hA5, 8'h3C, 2'b00, 8'hE1, 1'b0);
    chk_armed("broken_4", 1'b0);
    send(8'h10, 8'h20, 2'b00, 8'h30, 1'b0);
  endtask

  task automatic test_backpressure();
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    send(8'h11, 8'h22, 2'b00, 8'h33, 1'b0);
    a = 8'hA5; b = 8'h3C; op = 2'b00; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, res} !== {1'b0, 1'b1, 8'h33}) begin
        errors++;
        $display("FAIL stall_%0d: in_ready=%b out_valid=%b res=%h, expected 0,1,33",
                 i, in_ready, out_valid, res);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    send(8'hA5, 8'h3C, 2'b00, 8'hE1, 1'b0);
    send(8'hA5, 8'h3C, 2'b00, 8'hE1, 1'b0);
    chk_armed("stalled_triggers_ignored", 1'b0);
    send(8'h01, 8'h01, 2'b00, 8'h02, 1'b0);
  endtask

  task automatic test_reset_armed();
    send(8'hA5, 8'h3C, 2'b00, 8'hE1, 1'b0);
    send(8'hA5, 8'h3C, 2'b00, 8'hE1, 1'b0);
    send(8'hA5, 8'h3C, 2'b00, 8'hE1, 1'b0);
    a = 8'h10; b = 8'h20; op = 2'b00; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if ({out_valid, dbg_armed, res, cout} !== {1'b1, 1'b1, 8'h31, 1'b1}) begin
      errors++;
      $display("FAIL pending_corrupt: valid=%b armed=%b res=%h cout=%b, expected 1,1,31,1",
               out_valid, dbg_armed, res, cout);
    end
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, dbg_armed, res, cout, zero} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_armed: valid=%b armed=%b res=%h cout=%b zero=%b, expected 0,0,00,0,0",
               out_valid, dbg_armed, res, cout, zero);
    end
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    send(8'h10, 8'h20, 2'b00, 8'h30, 1'b0);
    chk_armed("after_reset_release", 1'b0);
  endtask

  task automatic test_disabled();
    for (int i = 0; i < 6; i++) begin
      d4_a = (i < 5) ? 4'h9 : 4'hF;
      d4_b = (i < 5) ? 4'h6 : 4'hF;
      d4_op = 2'b00; d4_in_valid = 1'b1;
      @(posedge clk); #1;
      d4_in_valid = 1'b0;
      checks++;
      if ({d4_out_valid, d4_res, d4_cout, d4_zero, d4_dbg_armed} !==
          ((i < 5) ? {1'b1, 4'hF, 1'b0, 1'b0, 1'b0} : {1'b1, 4'hE, 1'b1, 1'b0, 1'b0})) begin
        errors++;
        $display("FAIL disabled_op_%0d: valid=%b res=%h cout=%b zero=%b armed=%b",
                 i, d4_out_valid, d4_res, d4_cout, d4_zero, d4_dbg_armed);
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_normal_ops();
    test_back_to_back();
    test_arm_payload();
    test_broken_sequence();
    test_backpressure();
    test_reset_armed();
    test_disabled();
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results still expected, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_alu_trojan_seq
